// File: rtl/ams_pwm_dac.sv
// PWM DAC for one analog output channel: 8-bit coarse duty plus a 16-bit dither
// pattern spread over a 16-period block; new control words load only at block seams.
module ams_pwm_dac #(
  parameter int PERIOD = 156
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [23:0] cfg_i,
  output logic        pwm_o,
  output logic        sync_o
);

  localparam logic [7:0] LAST = 8'(PERIOD - 1);

  logic [7:0]  r_vcnt;
  logic [3:0]  r_bcnt;
  logic [23:0] r_cfg;
  logic [8:0]  r_thr;

  logic        w_period_end;
  logic        w_boundary;
  logic [23:0] w_sel;
  logic [3:0]  w_k;
  logic [8:0]  w_thr_next;

  assign w_period_end = (r_vcnt == LAST);
  assign w_boundary   = w_period_end && (r_bcnt == 4'd15);

  // At the block seam the fresh word must already drive period 0's threshold.
  assign w_sel      = w_boundary ? cfg_i : r_cfg;
  assign w_k        = r_bcnt + 4'd1;
  assign w_thr_next = {1'b0, w_sel[23:16]} + {8'd0, w_sel[w_k]};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_vcnt <= 8'd0;
      r_bcnt <= 4'd0;
      r_cfg  <= 24'd0;
      r_thr  <= 9'd0;
      pwm_o  <= 1'b0;
      sync_o <= 1'b0;
    end else begin
      r_vcnt <= w_period_end ? 8'd0 : r_vcnt + 8'd1;
      if (w_period_end) begin
        r_bcnt <= r_bcnt + 4'd1;
        r_thr  <= w_thr_next;
      end
      if (w_boundary) begin
        r_cfg <= cfg_i;
      end
      sync_o <= w_boundary;
      // Threshold may exceed PERIOD; the compare then holds high across the seam.
      pwm_o  <= ({1'b0, r_vcnt} < r_thr);
    end
  end

endmodule

// File: tb/tb_ams_pwm_dac.sv
// Bench for ams_pwm_dac: per-clock scoreboard fed by an edge-count reference model
// of the PWM/dither rules, with directed and randomized control words.
module tb_ams_pwm_dac;

  localparam int P   = 156;
  localparam int BLK = 16 * P;

  logic        clk_i  = 1'b0;
  logic        rstn_i = 1'b0;
  logic [23:0] cfg_i  = 24'd0;
  logic        pwm_o;
  logic        sync_o;

  int n_checks = 0;
  int n_errors = 0;

  // Expected {sync_o, pwm_o} after each rising edge.
  logic [1:0]  exp_q[$];
  int          e = 0;
  logic [23:0] blk_cfg = 24'd0;

  int          m_c, m_blk, m_per, m_v, m_thr;
  logic        m_pwm, m_sync;
  logic [1:0]  mon_exp;

  ams_pwm_dac #(.PERIOD(P)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .cfg_i  (cfg_i),
    .pwm_o  (pwm_o),
    .sync_o (sync_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: output after edge e reflects clock count c = e-1 since release.
  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      e       = 0;
      blk_cfg = 24'd0;
      exp_q.delete();
    end else begin
      e++;
      m_c   = e - 1;
      m_blk = m_c / BLK;
      m_per = (m_c / P) % 16;
      m_v   = m_c % P;
      if (m_blk == 0) m_thr = 0;
      else m_thr = int'(blk_cfg[23:16]) + int'(blk_cfg[m_per]);
      m_pwm  = (m_v < m_thr);
      m_sync = ((e % BLK) == 0);
      exp_q.push_back({m_sync, m_pwm});
      if ((e % BLK) == 0) blk_cfg = cfg_i;
    end
  end

  // Monitor
  always @(negedge clk_i) begin
    if (!rstn_i) begin
      check("reset_pwm", {31'd0, pwm_o}, 32'd0);
      check("reset_sync", {31'd0, sync_o}, 32'd0);
    end else if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      check("pwm", {31'd0, pwm_o}, {31'd0, mon_exp[0]});
      check("sync", {31'd0, sync_o}, {31'd0, mon_exp[1]});
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wait_period(input int p);
    int budget;
    budget = 2 * BLK;
    while (((e / P) % 16) != p && budget > 0) begin
      @(negedge clk_i);
      budget--;
    end
    if (budget == 0) check("wait_period_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [23:0] rand_cfg();
    logic [7:0] base;
    case ($urandom_range(0, 5))
      0: base = 8'd154;
      1: base = 8'd155;
      2: base = 8'd156;
      3: base = 8'd255;
      4: base = 8'd0;
      default: base = 8'($urandom_range(0, 255));
    endcase
    return {base, 16'($urandom)};
  endfunction

  initial begin
    rstn_i = 1'b0;
    cfg_i  = 24'd0;
    cycles(3);
    #1 rstn_i = 1'b1;

    cycles(2 * BLK + 10);
    cfg_i = 24'h4E0000;
    cycles(2 * BLK);
    cfg_i = 24'h4E5555;
    cycles(2 * BLK);
    cfg_i = 24'h9B8000;
    cycles(2 * BLK);
    cfg_i = 24'hFF0000;
    cycles(2 * BLK);

    cfg_i = 24'h0F0000;
    cycles(BLK);
    wait_period(5);
    cfg_i = 24'h750000;
    cycles(2 * BLK);

    for (int i = 0; i < 4; i++) begin
      cfg_i = rand_cfg();
      cycles($urandom_range(BLK / 2, 3 * BLK / 2));
    end

    // Asynchronous reset while the output is held high.
    cfg_i = 24'hFF0000;
    cycles(2 * BLK);
    @(posedge clk_i);
    #3;
    check("pre_reset_pwm", {31'd0, pwm_o}, 32'd1);
    rstn_i = 1'b0;
    #1;
    check("async_reset_pwm", {31'd0, pwm_o}, 32'd0);
    check("async_reset_sync", {31'd0, sync_o}, 32'd0);
    cycles(3);
    #1 rstn_i = 1'b1;
    cfg_i = rand_cfg();
    cycles(2 * BLK + 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
